ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
Parametrised successor of the top-level instruction fetch unit. It replaces the single-instruction IFU/PC/ITCM coupling with a decoupled prefetch engine. The engine issues sequential word fetches to a fixed-latency instruction memory and queues {pc, ir} pairs in a DEPTH-entry FIFO. It delivers them to the EXU over a valid/ready handshake, and redirects on flush (branch, trap, pipe flush) by discarding queued and in-flight fetches.

Parameters:
PC_SIZE, 32, PC and fetch address width
XLEN, 32, instruction word width
DEPTH, 4, prefetch FIFO entries; power of 2, >=2
MEM_LAT, 1, memory read latency in cycles; 1..4
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
ifu_i_redirect_req  in  1  flush request (bjp/excp/irq/pipe flush, pre-ORed)
ifu_i_redirect_pc  in  PC_SIZE  target PC for redirect
itcm_o_req  out  1  fetch request strobe
itcm_o_addr  out  PC_SIZE  word-aligned fetch address
itcm_i_rdata  in  XLEN  read data, valid exactly MEM_LAT cycles after the req cycle; no backpressure
ifu_o_ifu_valid  out  1  head entry valid
ifu_i_exu_ready  in  1  EXU accepts head entry
ifu_o_pc_r  out  PC_SIZE  PC of head entry
ifu_o_ir_r  out  XLEN  instruction of head entry
ifu_o_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: fetch_pc=RESET_PC; FIFO empty; in-flight tags cleared; itcm_o_req=0, itcm_o_addr=RESET_PC, ifu_o_ifu_valid=0, ifu_o_pc_r=0, ifu_o_ir_r=0, ifu_o_level=0. Reset mid-fetch drops everything; no stale data is ever pushed.
- Credit: itcm_o_req=1 iff !ifu_i_redirect_req && (level + inflight) < DEPTH. inflight = number of set tags in the MEM_LAT-stage tag shift register. A pop in the same cycle earns no credit.
- Issue: itcm_o_addr=fetch_pc (combinational from register). On req, fetch_pc <= fetch_pc+4; wraps modulo 2^PC_SIZE.
- Tag pipe: MEM_LAT stages of {valid, pc}. Stage 0 is loaded with {itcm_o_req, fetch_pc}. When the last stage is valid, {pc, itcm_i_rdata} is pushed into the FIFO that cycle.
- Credit guarantees the FIFO is never pushed when full. An overflow is a design error; the bench asserts it never happens.
- Pop: on ifu_o_ifu_valid && ifu_i_exu_ready, the head advances. Outputs come from the head entry as registered storage; no combinational path from rdata to outputs.
- ifu_o_ifu_valid = (level != 0). When level==0, ifu_o_pc_r and ifu_o_ir_r hold their last values.
- Simultaneous push and pop: level unchanged, both take effect.
- Redirect (cycle T): FIFO cleared (level=0 at T+1); all tag valids cleared, so in-flight responses are discarded. No req issues in T. fetch_pc <= {redirect_pc[PC_SIZE-1:2],2'b00}.
  - A handshake in cycle T is considered completed by the EXU; no error.
  - A push that would occur in T is dropped.
- Redirect latency: req at T+1 with addr=redirect target. Data is pushed at T+1+MEM_LAT; ifu_o_ifu_valid=1 at T+2+MEM_LAT.
- Back-to-back redirects: the last one wins; each clears state again.
- Throughput: sustains 1 instr/cycle with ready held high iff DEPTH >= MEM_LAT+2. Otherwise it degrades to DEPTH per (MEM_LAT+2) cycles, with no loss or duplication.
- Arithmetic: level and pointers wrap modulo DEPTH using an extra MSB for full/empty. PC increment is unsigned and truncated to PC_SIZE.

Test Plan:
- Reset release, ready=1, MEM_LAT=1, DEPTH=4, memory returns addr as data: req at addresses 0x80000000, 04, 08, ... First valid in cycle 3 after reset release, pc_r=0x80000000, ir_r=0x80000000. Then 1 instr/cycle, consecutive PCs, no gaps.
- ready=0 for 20 cycles: level saturates at 4, itcm_o_req=0 once level+inflight=4. Raising ready yields exactly 4 queued PCs in order, then streaming resumes without a skipped or duplicated PC.
- Redirect to 0x80000102 while 3 entries are queued and 1 is in flight: level=0 next cycle, next req addr=0x80000100. First delivered pc_r=0x80000100. The in-flight old data never appears.
- Redirect asserted on the same cycle as valid&&ready and as an in-flight response push: the pushed entry is dropped and the next delivered PC is the redirect target.
- MEM_LAT=3, DEPTH=2, ready=1: throughput = 2 instr per 5 cycles. Every PC from RESET_PC is delivered exactly once.
- fetch_pc at 0xFFFFFFFC: next req addr=0x00000000. rst_n asserted mid-stream: all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - decoupled instruction prefetch engine (credit-limited fetch, tag pipe, {pc, ir} FIFO)
//
// Purpose:
//   Issues sequential word fetches to a fixed-latency instruction memory.
//   Fetch results are queued as {pc, ir} pairs in a DEPTH-entry FIFO and
//   handed to the EXU over a valid/ready handshake. A redirect discards both
//   the queued and the in-flight fetches, then restarts fetching at the
//   word-aligned target.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   ifu_i_redirect_req  flush request (branch, trap, pipe flush, pre-ORed)
//   ifu_i_redirect_pc   redirect target PC (low two bits ignored)
//   itcm_o_req          fetch request strobe
//   itcm_o_addr         word-aligned fetch address (current fetch_pc)
//   itcm_i_rdata        read data, valid MEM_LAT cycles after the request
//   ifu_o_ifu_valid     head entry valid
//   ifu_i_exu_ready     EXU accepts head entry
//   ifu_o_pc_r          PC of head entry (holds last value when empty)
//   ifu_o_ir_r          instruction of head entry (holds last value when empty)
//   ifu_o_level         FIFO occupancy
module ifu_prefetch #(
  parameter int                 PC_SIZE  = 32,
  parameter int                 XLEN     = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 MEM_LAT  = 1,
  parameter logic [PC_SIZE-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ifu_i_redirect_req,
  input  logic [PC_SIZE-1:0]        ifu_i_redirect_pc,
  output logic                      itcm_o_req,
  output logic [PC_SIZE-1:0]        itcm_o_addr,
  input  logic [XLEN-1:0]           itcm_i_rdata,
  output logic                      ifu_o_ifu_valid,
  input  logic                      ifu_i_exu_ready,
  output logic [PC_SIZE-1:0]        ifu_o_pc_r,
  output logic [XLEN-1:0]           ifu_o_ir_r,
  output logic [$clog2(DEPTH):0]    ifu_o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Wide enough to hold level + inflight without overflow (MEM_LAT <= 4).
  localparam int CW = AW + 4;

  logic [PC_SIZE-1:0] r_fetch_pc;
  logic               r_run;
  logic [MEM_LAT-1:0] r_tag_vld;
  logic [PC_SIZE-1:0] r_tag_pc [MEM_LAT];
  logic [PC_SIZE-1:0] r_q_pc   [DEPTH];
  logic [XLEN-1:0]    r_q_ir   [DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic [PC_SIZE-1:0] r_hold_pc;
  logic [XLEN-1:0]    r_hold_ir;

  logic [LW-1:0]      w_level;
  logic [CW-1:0]      w_inflight;
  logic [CW-1:0]      w_used;
  logic               w_req;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic [AW-1:0]      w_head;
  logic [PC_SIZE-1:0] w_target;
  logic [PC_SIZE-1:0] w_pc_out;
  logic [XLEN-1:0]    w_ir_out;

  assign w_level = r_wptr - r_rptr;
  assign w_head  = r_rptr[AW-1:0];
  assign w_valid = (w_level != '0);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_tag_vld[i]);
    end
  end

  // Credit counts queued entries plus fetches still in the tag pipe, so a
  // response always has a free slot. A same-cycle pop is deliberately not
  // credited, which keeps the request path free of ifu_i_exu_ready.
  assign w_used = CW'(w_level) + w_inflight;
  assign w_req  = r_run && !ifu_i_redirect_req && (w_used < CW'(DEPTH));

  assign w_push = r_tag_vld[MEM_LAT-1] && !ifu_i_redirect_req;
  assign w_pop  = w_valid && ifu_i_exu_ready;

  assign w_target = ifu_i_redirect_pc & ~PC_SIZE'(3);

  // r_run keeps the request low while reset is asserted and for the first
  // cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (ifu_i_redirect_req) begin
      r_fetch_pc <= w_target;
    end else if (w_req) begin
      r_fetch_pc <= r_fetch_pc + PC_SIZE'(4);
    end
  end

  // Tag pipe: one stage per cycle of memory latency. The last stage lines up
  // with itcm_i_rdata. A redirect kills every stage so stale data is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        r_tag_pc[i] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_req;
      r_tag_pc[0]  <= r_fetch_pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tag_vld[i] <= ifu_i_redirect_req ? 1'b0 : r_tag_vld[i-1];
        r_tag_pc[i]  <= r_tag_pc[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (ifu_i_redirect_req) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + LW'(1);
      end
    end
  end

  // Entry storage needs no reset: it is only read while its slot is
  // occupied, and occupancy is reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wptr[AW-1:0]] <= r_tag_pc[MEM_LAT-1];
      r_q_ir[r_wptr[AW-1:0]] <= itcm_i_rdata;
    end
  end

  // The hold registers track whatever was shown last, so an empty FIFO
  // (after a drain or a redirect) keeps presenting the last head.
  assign w_pc_out = w_valid ? r_q_pc[w_head] : r_hold_pc;
  assign w_ir_out = w_valid ? r_q_ir[w_head] : r_hold_ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_pc <= '0;
      r_hold_ir <= '0;
    end else begin
      r_hold_pc <= w_pc_out;
      r_hold_ir <= w_ir_out;
    end
  end

  assign itcm_o_req      = w_req;
  assign itcm_o_addr     = r_fetch_pc;
  assign ifu_o_ifu_valid = w_valid;
  assign ifu_o_pc_r      = w_pc_out;
  assign ifu_o_ir_r      = w_ir_out;
  assign ifu_o_level     = w_level;

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - self-checking bench for ifu_prefetch
module tb_ifu_prefetch;

  localparam logic [31:0] A    = 32'h8000_0000;
  localparam logic [31:0] XORV = 32'h1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // DUT 1: DEPTH=4, MEM_LAT=1
  logic        rst_n = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        req1;
  logic [31:0] addr1;
  logic [31:0] rdata1;
  logic        vld1;
  logic        rdy1 = 1'b0;
  logic [31:0] pc1;
  logic [31:0] ir1;
  logic [2:0]  lvl1;

  ifu_prefetch #(.PC_SIZE(32), .XLEN(32), .DEPTH(4), .MEM_LAT(1), .RESET_PC(A)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_i_redirect_req(redir), .ifu_i_redirect_pc(redir_pc),
    .itcm_o_req(req1), .itcm_o_addr(addr1), .itcm_i_rdata(rdata1),
    .ifu_o_ifu_valid(vld1), .ifu_i_exu_ready(rdy1),
    .ifu_o_pc_r(pc1), .ifu_o_ir_r(ir1), .ifu_o_level(lvl1)
  );

  logic [31:0] m1_q;
  always @(posedge clk) m1_q <= addr1;
  assign rdata1 = m1_q ^ XORV;

  // DUT 2: DEPTH=2, MEM_LAT=3
  logic        rst2_n = 1'b0;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2;
  logic        vld2;
  logic        rdy2 = 1'b1;
  logic [31:0] pc2;
  logic [31:0] ir2;
  logic [1:0]  lvl2;

  ifu_prefetch #(.PC_SIZE(32), .XLEN(32), .DEPTH(2), .MEM_LAT(3), .RESET_PC(A)) u_dut2 (
    .clk(clk), .rst_n(rst2_n),
    .ifu_i_redirect_req(1'b0), .ifu_i_redirect_pc(32'h0),
    .itcm_o_req(req2), .itcm_o_addr(addr2), .itcm_i_rdata(rdata2),
    .ifu_o_ifu_valid(vld2), .ifu_i_exu_ready(rdy2),
    .ifu_o_pc_r(pc2), .ifu_o_ir_r(ir2), .ifu_o_level(lvl2)
  );

  logic [31:0] m2_q [3];
  always @(posedge clk) begin
    m2_q[0] <= addr2;
    m2_q[1] <= m2_q[0];
    m2_q[2] <= m2_q[1];
  end
  assign rdata2 = m2_q[2] ^ XORV;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // A FIFO overflow would show up as occupancy beyond DEPTH.
  always @(negedge clk) begin
    if (rst_n && lvl1 > 3'd4) begin
      n_err++;
      $display("FAIL overflow1: actual=%0d required<=4", lvl1);
    end
    if (rst2_n && lvl2 > 2'd2) begin
      n_err++;
      $display("FAIL overflow2: actual=%0d required<=2", lvl2);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          rep;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [2:0]  lvl;
  } vec_t;

  function automatic vec_t mk(int rep, logic rdy, logic rd, logic [31:0] rpc, logic req,
                              logic [31:0] addr, logic vld, logic [31:0] pc, logic [2:0] lvl, bit zir);
    vec_t v;
    v.rep = rep; v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.req = req; v.addr = addr;
    v.vld = vld; v.pc = pc; v.lvl = lvl;
    v.ir  = zir ? 32'h0 : (pc ^ XORV);
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    int cyc;
    int first;
    int npop;
    int nwin;
    logic [31:0] exp_pc;

    // Columns: rep, ready, redirect, redirect_pc | req, addr, valid, pc, level, ir-is-reset-zero
    vt.push_back(mk(1, 1, 0, 0, 0, 32'h8000_0000, 0, 32'h0, 0, 1));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0000, 0, 32'h0, 0, 1));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0004, 0, 32'h0, 0, 1));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0008, 1, 32'h8000_0000, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_000C, 1, 32'h8000_0004, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0010, 1, 32'h8000_0008, 1, 0));
    // ready low for 20 cycles: queue fills to 4, then req stops
    vt.push_back(mk(1, 0, 0, 0, 1, 32'h8000_0014, 1, 32'h8000_000C, 1, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 32'h8000_0018, 1, 32'h8000_000C, 2, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 32'h8000_001C, 1, 32'h8000_000C, 3, 0));
    vt.push_back(mk(17, 0, 0, 0, 0, 32'h8000_001C, 1, 32'h8000_000C, 4, 0));
    // drain in order, streaming resumes
    vt.push_back(mk(1, 1, 0, 0, 0, 32'h8000_001C, 1, 32'h8000_000C, 4, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_001C, 1, 32'h8000_0010, 3, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0020, 1, 32'h8000_0014, 2, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0024, 1, 32'h8000_0018, 2, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0028, 1, 32'h8000_001C, 2, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_002C, 1, 32'h8000_0020, 2, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 32'h8000_0030, 1, 32'h8000_0024, 2, 0));
    // redirect with 3 queued and 1 in flight
    vt.push_back(mk(1, 0, 1, 32'h8000_0102, 0, 32'h8000_0034, 1, 32'h8000_0024, 3, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0100, 0, 32'h8000_0024, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0104, 0, 32'h8000_0024, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0108, 1, 32'h8000_0100, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_010C, 1, 32'h8000_0104, 1, 0));
    // redirect together with a handshake and a response push
    vt.push_back(mk(1, 1, 1, 32'h8000_0200, 0, 32'h8000_0110, 1, 32'h8000_0108, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0200, 0, 32'h8000_0108, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0204, 0, 32'h8000_0108, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0208, 1, 32'h8000_0200, 1, 0));
    // back-to-back redirects, last wins
    vt.push_back(mk(1, 1, 1, 32'h8000_0300, 0, 32'h8000_020C, 1, 32'h8000_0204, 1, 0));
    vt.push_back(mk(1, 1, 1, 32'h8000_0404, 0, 32'h8000_0300, 0, 32'h8000_0204, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0404, 0, 32'h8000_0204, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_0408, 0, 32'h8000_0204, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h8000_040C, 1, 32'h8000_0404, 1, 0));
    // fetch address wrap
    vt.push_back(mk(1, 1, 1, 32'hFFFF_FFF8, 0, 32'h8000_0410, 1, 32'h8000_0408, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h8000_0408, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h8000_0408, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000, 1, 0));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.req",   32'(req1),  32'h0);
    chk("rst.addr",  addr1,      A);
    chk("rst.valid", 32'(vld1),  32'h0);
    chk("rst.pc",    pc1,        32'h0);
    chk("rst.ir",    ir1,        32'h0);
    chk("rst.level", 32'(lvl1),  32'h0);

    rst_n = 1'b1;
    cyc = 0;
    foreach (vt[i]) begin
      for (int r = 0; r < vt[i].rep; r++) begin
        rdy1 = vt[i].rdy; redir = vt[i].rd; redir_pc = vt[i].rpc;
        #1;
        chk($sformatf("v%0d.%0d.req", i, r),   32'(req1), 32'(vt[i].req));
        chk($sformatf("v%0d.%0d.addr", i, r),  addr1,     vt[i].addr);
        chk($sformatf("v%0d.%0d.valid", i, r), 32'(vld1), 32'(vt[i].vld));
        chk($sformatf("v%0d.%0d.pc", i, r),    pc1,       vt[i].pc);
        chk($sformatf("v%0d.%0d.ir", i, r),    ir1,       vt[i].ir);
        chk($sformatf("v%0d.%0d.level", i, r), 32'(lvl1), 32'(vt[i].lvl));
        @(negedge clk);
        cyc++;
      end
    end

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst.req",   32'(req1), 32'h0);
    chk("arst.addr",  addr1,     A);
    chk("arst.valid", 32'(vld1), 32'h0);
    chk("arst.pc",    pc1,       32'h0);
    chk("arst.ir",    ir1,       32'h0);
    chk("arst.level", 32'(lvl1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; rdy1 = 1'b1; redir = 1'b0;
    #1;
    chk("rel0.req", 32'(req1), 32'h0);
    @(negedge clk); #1;
    chk("rel1.req",  32'(req1), 32'h1);
    chk("rel1.addr", addr1,     A);
    first = -1;
    for (int k = 2; k < 12; k++) begin
      @(negedge clk); #1;
      if (vld1) begin
        first = k;
        break;
      end
    end
    chk("rel.first_valid_cycle", 32'(first), 32'd3);
    chk("rel.pc", pc1, A);
    chk("rel.ir", ir1, A ^ XORV);

    // DEPTH=2, MEM_LAT=3: 2 instructions per 5 cycles, every PC exactly once
    @(negedge clk);
    rst2_n = 1'b1;
    exp_pc = A;
    npop = 0; nwin = 0; first = -1;
    for (int k = 0; k < 60; k++) begin
      #1;
      chk($sformatf("d2.c%0d.level", k), 32'(lvl2 <= 2'd2), 32'h1);
      if (vld2 && rdy2) begin
        if (first < 0) first = k;
        chk($sformatf("d2.pop%0d.pc", npop), pc2, exp_pc);
        chk($sformatf("d2.pop%0d.ir", npop), ir2, exp_pc ^ XORV);
        exp_pc = exp_pc + 32'd4;
        npop++;
        if (k < first + 20) nwin++;
      end
      @(negedge clk);
    end
    chk("d2.first_valid_cycle", 32'(first), 32'd5);
    chk("d2.pops_in_20_cycles", 32'(nwin), 32'd8);
    chk("d2.total_pops", 32'(npop), 32'd22);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
